// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter that shares one single-port DataMemory between NREQ
// requesters. Lock lets the current owner keep the grant for a bounded burst.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req/we/lock [NREQ]  per-requester request, write enable, burst lock
//   addr/wdata          flattened, requester i uses [i*WL +: WL]
//   gnt [NREQ]          registered one-hot grant (all zero when idle)
//   rvalid [NREQ]       one-cycle pulse the cycle after a read beat
//   rdata [WL]          registered read data, shared, held until next read
//   mem_addr/mem_wdata  to DataMemory, muxed from the owner (0 when idle)
//   mem_we              to DataMemory, high only during a write beat
//   mem_rdata           from DataMemory, combinational read of mem_addr
//   dbg_state           current arbiter state (0 = IDLE, 1 = OWNED)
//
// Handshake: a requester raises req and holds addr/we/wdata stable until it
// sees gnt. A beat is any cycle with req[i] & gnt[i]; writes commit at the
// edge ending that cycle, reads return rdata with rvalid[i] one cycle later.
// gnt without req is an empty cycle: no beat, no write. req may be dropped
// before it is granted.
module dmem_arbiter #(
    parameter int NREQ     = 2,
    parameter int WL       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*WL-1:0] addr,
    input  logic [NREQ*WL-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [WL-1:0]      rdata,
    output logic [WL-1:0]      mem_addr,
    output logic [WL-1:0]      mem_wdata,
    output logic               mem_we,
    input  logic [WL-1:0]      mem_rdata,
    output logic               dbg_state
);

    localparam int OW = $clog2(NREQ);
    localparam int LW = $clog2(MAX_LOCK) + 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [WL-1:0]   rdata_q, rdata_d;

    logic            owned;
    logic            beat;
    logic            pick_found;
    logic [OW-1:0]   pick_idx;

    assign owned     = (state_q == S_OWNED);
    assign beat      = owned && req[owner_q];
    assign gnt       = owned ? (NREQ'(1) << owner_q) : '0;
    assign mem_addr  = owned ? addr[int'(owner_q)*WL +: WL] : '0;
    assign mem_wdata = owned ? wdata[int'(owner_q)*WL +: WL] : '0;
    assign mem_we    = beat && we[owner_q];
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

    // Rotating-priority search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req[(int'(ptr_q) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = OW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        lcnt_d   = lcnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;

        if (beat && !we[owner_q]) begin
            rvalid_d[owner_q] = 1'b1;
            rdata_d           = mem_rdata;
        end

        // The lock counter counts beats already taken in this burst, so the
        // owner stays only while fewer than MAX_LOCK beats have been used.
        if (owned && req[owner_q] && lock[owner_q] && (lcnt_q < LOCK_LAST)) begin
            lcnt_d = lcnt_q + 1'b1;
        end else if (pick_found) begin
            state_d = S_OWNED;
            owner_d = pick_idx;
            ptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
            lcnt_d  = '0;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            lcnt_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            lcnt_q   <= lcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int NREQ     = 2;
  localparam int WL       = 32;
  localparam int MAX_LOCK = 4;

  // clock / reset: posedges at 10, 20, 30 ... so a 25 ns reset ends mid-cycle
  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, we, lock;
  logic [NREQ*WL-1:0] addr, wdata;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [WL-1:0]      rdata, mem_addr, mem_wdata, mem_rdata;
  logic               mem_we;
  logic               dbg_state;

  dmem_arbiter #(.NREQ(NREQ), .WL(WL), .MAX_LOCK(MAX_LOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // DataMemory stand-in: 16 words, word i preloaded with C0DE_0000 | i
  logic [WL-1:0] mem [0:15];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [WL-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [NREQ-1:0] v_req, input logic v_we,
                       input logic [WL-1:0] v_addr, input logic [WL-1:0] v_wdata);
    req[r]            = v_req[r];
    we[r]             = v_we;
    addr[r*WL +: WL]  = v_addr;
    wdata[r*WL +: WL] = v_wdata;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;

    // reset state
    #3;
    chk("rst_gnt", WL'(gnt), 0);
    chk("rst_rvalid", WL'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_we", WL'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    #22 rst = 1'b0;

    // single read by requester 0 from 0x8
    #1 drive(0, 2'b01, 1'b0, 32'h8, 32'h0);
    edge1(); #1;
    chk("rd_gnt", WL'(gnt), 32'h1);
    chk("rd_mem_addr", mem_addr, 32'h8);
    chk("rd_mem_we", WL'(mem_we), 0);
    edge1(); req = '0; #1;
    chk("rd_rvalid", WL'(rvalid), 32'h1);
    chk("rd_rdata", rdata, 32'hC0DE_0008);
    edge1(); #1;
    chk("idle_gnt", WL'(gnt), 0);
    chk("idle_rvalid", WL'(rvalid), 0);
    chk("idle_rdata_hold", rdata, 32'hC0DE_0008);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_we", WL'(mem_we), 0);

    // requester 1 writes 15 to 0x4, then reads it back
    req = 2'b10; we = 2'b10; addr[WL +: WL] = 32'h4; wdata[WL +: WL] = 32'd15;
    edge1(); #1;
    chk("wr_gnt", WL'(gnt), 32'h2);
    chk("wr_mem_we", WL'(mem_we), 1);
    chk("wr_mem_addr", mem_addr, 32'h4);
    chk("wr_mem_wdata", mem_wdata, 32'd15);
    edge1(); we = '0; #1;
    chk("rb_gnt", WL'(gnt), 32'h2);
    chk("rb_mem_we", WL'(mem_we), 0);
    chk("wr_no_rvalid", WL'(rvalid), 0);
    edge1(); req = '0; #1;
    chk("rb_rvalid", WL'(rvalid), 32'h2);
    chk("rb_rdata", rdata, 32'd15);
    chk("rb_mem4", mem[4], 32'd15);

    // contention from reset: grants alternate starting with requester 0
    edge1(); rst = 1'b1;
    #2 rst = 1'b0;
    req = 2'b11; addr[0 +: WL] = 32'h1; addr[WL +: WL] = 32'h2;
    for (int k = 0; k < 6; k++) begin
      edge1(); #1;
      chk($sformatf("ct_gnt%0d", k), WL'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        chk($sformatf("ct_rvalid%0d", k), WL'(rvalid), (k % 2 == 0) ? 32'h2 : 32'h1);
        chk($sformatf("ct_rdata%0d", k), rdata, (k % 2 == 0) ? 32'hC0DE_0002 : 32'hC0DE_0001);
      end
    end

    // locked burst: requester 1 (already owning) holds 4 beats, 0 gets one, back to 1
    lock = 2'b10;
    exp_q = '{32'h2, 32'h2, 32'h2, 32'h1, 32'h2, 32'h2};
    for (int j = 0; j < 6; j++) begin
      edge1(); #1;
      chk($sformatf("lk_gnt%0d", j), WL'(gnt), exp_q.pop_front());
    end
    req = '0; lock = '0;

    // withdrawn write request: grant may arrive, but nothing is written
    edge1(); #1;
    chk("wd_idle_gnt", WL'(gnt), 0);
    drive(0, 2'b01, 1'b1, 32'h3, 32'hDEAD_BEEF);
    edge1(); req = '0; #1;
    chk("wd_gnt", WL'(gnt), 32'h1);
    chk("wd_mem_we", WL'(mem_we), 0);
    edge1(); #1;
    chk("wd_gnt_drop", WL'(gnt), 0);
    chk("wd_mem3", mem[3], 32'hC0DE_0003);

    // async reset 3 ns into a read beat
    drive(0, 2'b01, 1'b0, 32'h5, 32'h0);
    edge1(); #1;
    chk("ar_gnt", WL'(gnt), 32'h1);
    edge1(); #1;
    chk("ar_rvalid", WL'(rvalid), 32'h1);
    chk("ar_rdata", rdata, 32'hC0DE_0005);
    #1 rst = 1'b1;
    #1;
    chk("ar_gnt0", WL'(gnt), 0);
    chk("ar_rvalid0", WL'(rvalid), 0);
    chk("ar_rdata0", rdata, 0);
    chk("ar_mem_we0", WL'(mem_we), 0);
    #2 rst = 1'b0; req = 2'b11;
    edge1(); #1;
    chk("ar_resume_gnt", WL'(gnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter sharing the single-port DataMemory between NREQ requesters, e.g. the RISC_V core data port and a loader/DMA engine.
- Each requester uses a req/gnt handshake and gets registered read data.
- Supports locked bursts with a bounded lock length so no requester starves.
- Sits between the requesters and DataMemory's addressIN/dataIN/writeEN/dataOUT.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WL, 32, address/data word length.
- MAX_LOCK, 4, maximum consecutive beats one owner may hold via lock (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-requester access request.
- we  input  NREQ  per-requester write enable (1=write, 0=read).
- lock  input  NREQ  requester asks to keep the grant after this beat.
- addr  input  NREQ*WL  flattened addresses; requester i uses bits [i*WL +: WL].
- wdata  input  NREQ*WL  flattened write data, same slicing as addr.
- gnt  output  NREQ  registered one-hot grant.
- rvalid  output  NREQ  one-cycle read-data-valid pulse, per requester.
- rdata  output  WL  registered read data, shared by all requesters.
- mem_addr  output  WL  to DataMemory address.
- mem_wdata  output  WL  to DataMemory write data.
- mem_we  output  1  to DataMemory write enable.
- mem_rdata  input  WL  from DataMemory; combinational read of mem_addr.

Behaviour:
- Reset (async, immediate):
  - gnt=0, rvalid=0, rdata=0.
  - Round-robin pointer ptr=0, lock counter lcnt=0.
  - mem_we=0 while gnt=0.
- Beat (transfer) definition:
  - A beat occurs in any cycle where req[i] & gnt[i].
  - mem_addr and mem_wdata are muxed combinationally from the owner's addr/wdata slices.
  - mem_addr = mem_wdata = 0 when gnt=0.
  - mem_we = req[o] & gnt[o] & we[o].
  - If gnt[o]=1 but req[o]=0, there is no beat and mem_we=0.
- Requester rules:
  - Hold addr, we and wdata stable while req=1 and gnt=0.
  - req may be withdrawn before it is granted.
- Write beat: the write commits at the clock edge that ends the beat cycle.
- Read beat:
  - rdata <= mem_rdata at the edge that ends the beat.
  - rvalid[o]=1 for exactly the following cycle; rdata holds its value until the next read beat.
  - Read latency is 1 cycle after the beat cycle.
- Arbitration at every rising edge. States: IDLE (gnt=0) and OWNED(o) (gnt one-hot at o).
  - Lock continuation:
    - Condition: in OWNED(o), req[o]&lock[o] at the edge and lcnt < MAX_LOCK-1.
    - Action: stay in OWNED(o), lcnt++ and ptr unchanged.
  - Otherwise, rotating priority selection:
    - Pick the first i with req[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, … (wraps modulo NREQ).
    - On a pick: go to OWNED(i), ptr <= (i+1) mod NREQ, lcnt <= 0.
    - If no request: go to IDLE; ptr and lcnt are unchanged.
  - A req sampled while gnt for the same requester is high counts as a new request.
    - Back-to-back beats for a lone requester therefore happen every cycle.
    - When others are requesting, priority rotates away.
- Lock limit: after MAX_LOCK consecutive beats, re-arbitration is forced even if lock stays high.
- Grant latency: a request raised in cycle k (seen at edge k+1) is granted from cycle k+1 at the earliest.
- Fairness bound: with all NREQ requesting continuously without lock, each requester is granted once every NREQ cycles.
- Only one gnt bit is ever high ($onehot0 invariant); one beat per cycle maximum.
- Reset asserted mid-beat:
  - gnt drops immediately and the pending rvalid is cancelled.
  - A write whose commit edge has not occurred is not performed, because mem_we drops.

Test Plan:
- Reset then single read:
  - Stimulus: rst high 25 ns, release; req[0]=1, we=0, addr0=0x8.
  - Response: gnt=2'b01 one cycle after sampling; in the next cycle rvalid[0]=1 and rdata=mem[8].
  - While gnt=0, mem_we=0 and mem_addr=0.
- Write then readback:
  - Stimulus: requester 1 writes wdata=15 to addr=0x4, then reads 0x4.
  - Response: mem_we=1 only in the beat cycle; the read returns rdata=15 with rvalid[1]=1.
- Contention:
  - Stimulus: req=2'b11 continuously, no lock, from reset (ptr=0).
  - Response: gnt alternates 01,10,01,10…; each requester gets 50% of beats.
- Locked burst:
  - Stimulus: MAX_LOCK=4; req=2'b11; lock[1]=1 after requester 1 is granted.
  - Response: requester 1 gets exactly 4 consecutive beats, then gnt=01 for one cycle, then back to 10.
- Withdrawn request:
  - Stimulus: req[0] pulses for 1 cycle with we=1, dropping before it is granted.
  - Response: gnt[0] may rise, but mem_we stays 0 and memory is unchanged.
- Async reset mid-operation:
  - Stimulus: rst asserted at 3 ns into a read beat.
  - Response: gnt, rvalid and rdata go to 0 within the same cycle with no clock edge; arbitration resumes from ptr=0 after release.
